// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU operation, rounding-mode and exception-flag encodings
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fpu_op_e;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } fpu_rm_e;

    localparam int EXC_W  = 5;
    localparam int EXC_OF = 4;
    localparam int EXC_UF = 3;
    localparam int EXC_DZ = 2;
    localparam int EXC_NV = 1;
    localparam int EXC_NX = 0;

endpackage

// File: rtl/fpu_sync_fifo.sv
// fpu_sync_fifo: synchronous FIFO with registered storage and full/empty/count status
module fpu_sync_fifo #(
    parameter int W = 8,
    parameter int D = 4,
    localparam int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem_q [D];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full  = cnt_q == (AW+1)'(D);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
    assign rdata = mem_q[rd_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d   = (do_push && !do_pop) ? cnt_q + (AW+1)'(1) :
                  (!do_push && do_pop) ? cnt_q - (AW+1)'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= wdata;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: credit-based FPU request buffer/issuer with tagged result buffer; FPU_ISSUE_STICKY_EXC_EN enables sticky exception flags
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int BIT_WIDTH = 64,
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int FPU_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [1:0]           i_req_op,
    input  logic [2:0]           i_req_mode,
    input  logic [BIT_WIDTH-1:0] i_req_a,
    input  logic [BIT_WIDTH-1:0] i_req_b,
    input  logic [TAG_W-1:0]     i_req_tag,
    output logic                 o_fpu_valid,
    output logic [1:0]           o_fpu_operation,
    output logic [2:0]           o_fpu_mode,
    output logic [BIT_WIDTH-1:0] o_fpu_inputA,
    output logic [BIT_WIDTH-1:0] o_fpu_inputB,
    input  logic [BIT_WIDTH-1:0] i_fpu_output,
    input  logic [EXC_W-1:0]     i_fpu_exeption,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [BIT_WIDTH-1:0] o_rsp_data,
    output logic [EXC_W-1:0]     o_rsp_exeption,
    output logic [TAG_W-1:0]     o_rsp_tag,
    input  logic                 i_exc_clear,
    output logic [EXC_W-1:0]     o_exc_sticky
);

    localparam int REQ_W = 5 + 2*BIT_WIDTH + TAG_W;
    localparam int RSP_W = BIT_WIDTH + EXC_W + TAG_W;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    logic                 req_full, req_empty, rsp_full_unused, rsp_empty;
    logic                 issue, cap, rsp_pop;
    logic [CW-1:0]        req_cnt_unused, rsp_cnt;
    logic [REQ_W-1:0]     req_rdata;
    logic [RSP_W-1:0]     rsp_rdata;
    logic [1:0]           h_op;
    logic [2:0]           h_mode;
    logic [BIT_WIDTH-1:0] h_a, h_b;
    logic [TAG_W-1:0]     h_tag;

    logic                 fpu_valid_q, fpu_valid_d;
    logic [1:0]           op_q, op_d;
    logic [2:0]           mode_q, mode_d;
    logic [BIT_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [CW-1:0]        inflight_q, inflight_d;
    logic [FPU_LAT-1:0]   pv_q, pv_d;
    logic [TAG_W-1:0]     pt_q [FPU_LAT];
    logic [TAG_W-1:0]     pt_d [FPU_LAT];
    logic [EXC_W-1:0]     sticky_q, sticky_d;

    assign o_req_ready = !rst && !req_full;
    assign {h_op, h_mode, h_a, h_b, h_tag} = req_rdata;

    fpu_sync_fifo #(.W(REQ_W), .D(DEPTH)) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_req_valid && o_req_ready),
        .wdata ({i_req_op, i_req_mode, i_req_a, i_req_b, i_req_tag}),
        .pop   (issue),
        .rdata (req_rdata),
        .full  (req_full),
        .empty (req_empty),
        .count (req_cnt_unused)
    );

    fpu_sync_fifo #(.W(RSP_W), .D(DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap),
        .wdata ({i_fpu_output, i_fpu_exeption, pt_q[FPU_LAT-1]}),
        .pop   (rsp_pop),
        .rdata (rsp_rdata),
        .full  (rsp_full_unused),
        .empty (rsp_empty),
        .count (rsp_cnt)
    );

    assign o_rsp_valid = !rsp_empty;
    assign rsp_pop     = o_rsp_valid && i_rsp_ready;
    assign {o_rsp_data, o_rsp_exeption, o_rsp_tag} = rsp_rdata;

    // Every in-flight op owns a reserved result slot, so capture can never overflow
    always_comb begin
        issue       = !req_empty && (({1'b0, inflight_q} + {1'b0, rsp_cnt}) < CREDITS);
        cap         = pv_q[FPU_LAT-1];
        fpu_valid_d = issue;
        op_d        = issue ? h_op : op_q;
        mode_d      = issue ? h_mode : mode_q;
        a_d         = issue ? h_a : a_q;
        b_d         = issue ? h_b : b_q;
        tag_d       = issue ? h_tag : tag_q;
        inflight_d  = (issue && !cap) ? inflight_q + CW'(1) :
                      (!issue && cap) ? inflight_q - CW'(1) : inflight_q;
        pv_d[0]     = fpu_valid_q;
        pt_d[0]     = tag_q;
        for (int i = 1; i < FPU_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pt_d[i] = pt_q[i-1];
        end
    end

`ifdef FPU_ISSUE_STICKY_EXC_EN
    assign sticky_d = (i_exc_clear ? '0 : sticky_q) | (rsp_pop ? o_rsp_exeption : '0);
`else
    logic unused_exc_clear;
    assign unused_exc_clear = i_exc_clear;
    assign sticky_d = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_valid_q <= 1'b0;
            op_q        <= '0;
            mode_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            inflight_q  <= '0;
            pv_q        <= '0;
            for (int i = 0; i < FPU_LAT; i++) pt_q[i] <= '0;
            sticky_q    <= '0;
        end else begin
            fpu_valid_q <= fpu_valid_d;
            op_q        <= op_d;
            mode_q      <= mode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tag_q       <= tag_d;
            inflight_q  <= inflight_d;
            pv_q        <= pv_d;
            pt_q        <= pt_d;
            sticky_q    <= sticky_d;
        end
    end

    assign o_fpu_valid     = fpu_valid_q;
    assign o_fpu_operation = op_q;
    assign o_fpu_mode      = mode_q;
    assign o_fpu_inputA    = a_q;
    assign o_fpu_inputB    = b_q;
    assign o_exc_sticky    = sticky_q;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb_fpu_issue_queue: scoreboard bench with a behavioural FPU; define FPU_ISSUE_STICKY_EXC_EN to expect sticky flags
module tb_fpu_issue_queue;

    localparam logic [63:0] ONE   = 64'h3FF0000000000000;
    localparam logic [63:0] TWO   = 64'h4000000000000000;
    localparam logic [63:0] THREE = 64'h4008000000000000;
    localparam logic [63:0] MONE  = 64'hBFF0000000000000;
    localparam logic [63:0] HALF  = 64'h3FE0000000000000;
    localparam logic [63:0] ZERO  = 64'h0;
    localparam logic [63:0] TINY  = 64'h3CA0000000000000;
    localparam logic [63:0] PINF  = 64'h7FF0000000000000;
`ifdef FPU_ISSUE_STICKY_EXC_EN
    localparam logic [4:0] STK_ACC = 5'b00101;
    localparam logic [4:0] STK_CLR = 5'b00001;
`else
    localparam logic [4:0] STK_ACC = 5'b00000;
    localparam logic [4:0] STK_CLR = 5'b00000;
`endif

    logic        clk, rst;
    logic        i_req_valid, o_req_ready;
    logic [1:0]  i_req_op;
    logic [2:0]  i_req_mode;
    logic [63:0] i_req_a, i_req_b;
    logic [3:0]  i_req_tag;
    logic        o_fpu_valid;
    logic [1:0]  o_fpu_operation;
    logic [2:0]  o_fpu_mode;
    logic [63:0] o_fpu_inputA, o_fpu_inputB;
    logic [63:0] i_fpu_output;
    logic [4:0]  i_fpu_exeption;
    logic        o_rsp_valid, i_rsp_ready;
    logic [63:0] o_rsp_data;
    logic [4:0]  o_rsp_exeption;
    logic [3:0]  o_rsp_tag;
    logic        i_exc_clear;
    logic [4:0]  o_exc_sticky;

    fpu_issue_queue dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_mode(i_req_mode),
        .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_tag(i_req_tag),
        .o_fpu_valid(o_fpu_valid), .o_fpu_operation(o_fpu_operation), .o_fpu_mode(o_fpu_mode),
        .o_fpu_inputA(o_fpu_inputA), .o_fpu_inputB(o_fpu_inputB),
        .i_fpu_output(i_fpu_output), .i_fpu_exeption(i_fpu_exeption),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_exeption(o_rsp_exeption), .o_rsp_tag(o_rsp_tag),
        .i_exc_clear(i_exc_clear), .o_exc_sticky(o_exc_sticky)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
        logic [4:0]  exc;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    logic [63:0] exp_tab [4];
    int n_vec = 0, n_bad = 0;
    int n_issue = 0, n_rspv = 0, fv_run = 0, fv_max = 0, rs_run = 0, rs_max = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [68:0] fpu_model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        real ra, rb, r;
        logic [4:0] x;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        x = 5'b0;
        if (op == 2'd3 && b[62:0] == 63'd0) return {PINF, 5'b00100};
        r = op == 2'd0 ? ra + rb : op == 2'd1 ? ra - rb : op == 2'd2 ? ra * rb : ra / rb;
        if (op == 2'd0 && a == ONE && b == TINY) x = 5'b00001;
        return {$realtobits(r), x};
    endfunction

    // Behavioural FPU with one cycle of latency
    always @(posedge clk or posedge rst) begin
        if (rst) {i_fpu_output, i_fpu_exeption} <= '0;
        else if (o_fpu_valid) {i_fpu_output, i_fpu_exeption} <= fpu_model(o_fpu_operation, o_fpu_inputA, o_fpu_inputB);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            fv_run = o_fpu_valid ? fv_run + 1 : 0;
            if (fv_run > fv_max) fv_max = fv_run;
            if (o_fpu_valid) n_issue++;
            if (o_rsp_valid) n_rspv++;
            if (o_rsp_valid && i_rsp_ready) begin
                rs_run++;
                if (rs_run > rs_max) rs_max = rs_run;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got tag %0h, required no response", o_rsp_tag);
                end else begin
                    e_mon = sb.pop_front();
                    chk("rsp_tag", 64'(o_rsp_tag), 64'(e_mon.tag));
                    chk("rsp_data", o_rsp_data, e_mon.data);
                    chk("rsp_exc", 64'(o_rsp_exeption), 64'(e_mon.exc));
                end
            end else rs_run = 0;
        end
    end

    task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] tag, input logic [63:0] ed, input logic [4:0] ee, output bit acc);
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_mode  = 3'(tag % 5);
        i_req_a     = a;
        i_req_b     = b;
        i_req_tag   = tag;
        acc = o_req_ready;
        if (acc) sb.push_back(exp_t'{tag, ed, ee});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        i_req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int lim);
        int k = 0;
        while (sb.size() != 0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_rv(input int lim);
        int k = 0;
        while (!o_rsp_valid && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_wait", 64'(o_rsp_valid), 64'd1);
    endtask

    initial begin
        bit acc;
        int nacc;
        exp_tab[0] = THREE;
        exp_tab[1] = MONE;
        exp_tab[2] = TWO;
        exp_tab[3] = HALF;
        rst = 1'b1;
        i_req_valid = 1'b0;
        i_req_op = '0;
        i_req_mode = '0;
        i_req_a = '0;
        i_req_b = '0;
        i_req_tag = '0;
        i_rsp_ready = 1'b1;
        i_exc_clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", 64'(o_req_ready), 64'd0);
        chk("reset_fpu_valid", 64'(o_fpu_valid), 64'd0);
        chk("reset_rsp_valid", 64'(o_rsp_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_req_ready", 64'(o_req_ready), 64'd1);

        send(2'd0, ONE, TWO, 4'd3, THREE, 5'd0, acc);
        chk("single_accept", 64'(acc), 64'd1);
        idle();
        chk("single_fv_c1", 64'(o_fpu_valid), 64'd0);
        @(negedge clk);
        chk("single_fv_c2", 64'(o_fpu_valid), 64'd1);
        chk("single_fpu_op", 64'(o_fpu_operation), 64'd0);
        chk("single_fpu_mode", 64'(o_fpu_mode), 64'd3);
        chk("single_fpu_a", o_fpu_inputA, ONE);
        chk("single_fpu_b", o_fpu_inputB, TWO);
        @(negedge clk);
        chk("single_fv_c3", 64'(o_fpu_valid), 64'd0);
        chk("single_rv_c3", 64'(o_rsp_valid), 64'd0);
        @(negedge clk);
        chk("single_rv_c4", 64'(o_rsp_valid), 64'd1);
        wait_drain(20);

        i_rsp_ready = 1'b0;
        n_issue = 0;
        nacc = 0;
        for (int t = 0; t < 10; t++) begin
            send(2'(t % 4), ONE, TWO, 4'(t), exp_tab[t % 4], 5'd0, acc);
            nacc += int'(acc);
        end
        idle();
        chk("bp_accepted", 64'(nacc), 64'd8);
        chk("bp_req_ready", 64'(o_req_ready), 64'd0);
        repeat (6) @(negedge clk);
        chk("bp_issued", 64'(n_issue), 64'd4);
        chk("bp_hold_valid", 64'(o_rsp_valid), 64'd1);
        chk("bp_hold_tag", 64'(o_rsp_tag), 64'd0);
        repeat (3) @(negedge clk);
        chk("bp_hold_tag2", 64'(o_rsp_tag), 64'd0);
        chk("bp_hold_data", o_rsp_data, THREE);
        i_rsp_ready = 1'b1;
        wait_drain(60);

        repeat (3) idle();
        fv_max = 0;
        rs_max = 0;
        for (int t = 0; t < 16; t++) send(2'(t % 4), ONE, TWO, 4'(t), exp_tab[t % 4], 5'd0, acc);
        idle();
        wait_drain(60);
        chk("stream_issue_run", 64'(fv_max), 64'd16);
        chk("stream_rsp_run", 64'(rs_max), 64'd16);

        send(2'd3, ONE, ZERO, 4'd1, PINF, 5'b00100, acc);
        send(2'd0, ONE, TINY, 4'd2, ONE, 5'b00001, acc);
        idle();
        wait_drain(30);
        chk("sticky_accum", 64'(o_exc_sticky), 64'(STK_ACC));
        i_rsp_ready = 1'b0;
        send(2'd0, ONE, TINY, 4'd3, ONE, 5'b00001, acc);
        idle();
        wait_rv(20);
        i_exc_clear = 1'b1;
        i_rsp_ready = 1'b1;
        @(negedge clk);
        i_exc_clear = 1'b0;
        chk("sticky_clear_hs", 64'(o_exc_sticky), 64'(STK_CLR));
        wait_drain(20);

        for (int t = 0; t < 4; t++) send(2'd0, ONE, TWO, 4'(t), THREE, 5'd0, acc);
        @(negedge clk);
        i_req_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_req_ready", 64'(o_req_ready), 64'd0);
        chk("midrst_fpu_valid", 64'(o_fpu_valid), 64'd0);
        chk("midrst_fpu_op", 64'(o_fpu_operation), 64'd0);
        chk("midrst_fpu_a", o_fpu_inputA, 64'd0);
        chk("midrst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("midrst_rsp_data", o_rsp_data, 64'd0);
        chk("midrst_rsp_tag", 64'(o_rsp_tag), 64'd0);
        chk("midrst_sticky", 64'(o_exc_sticky), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_rspv = 0;
        @(negedge clk);
        chk("postrst_req_ready", 64'(o_req_ready), 64'd1);
        repeat (10) @(negedge clk);
        chk("postrst_no_stale", 64'(n_rspv), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
